mem_port_arbiter: RTL and testbench

- Shares a single-ported unified memory between instruction fetch (IF stage) and data access (MEM stage) of the 5-stage pipeline.
- Sequences multi-cycle memory transactions via a req/ack handshake. Returns read data to the winning stage.
- Generates stall_fetch (gates write_PC / write_IFID) and stall_pipe (freezes the whole pipeline while a data access is outstanding).
- Honours branch flush: an in-flight fetch that has been flushed completes on the bus, but its data is discarded.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_ack_timeout_ctr.sv | 31 +++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Holds the FSM state encoding and the bus access-size codes.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        F_BUSY = 2'd2,
        F_DROP = 2'd3
    } arb_state_e;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    // True while a transaction owns the memory bus.
    function automatic logic is_busy(arb_state_e s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_ack_timeout_ctr.sv
// Down-counter that flags a bus master waiting too long for an acknowledge.
// TIMEOUT = 0 disables the check; expired_c fires on the TIMEOUT-th waiting cycle.
module ack_timeout_ctr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clock,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // Reload while cleared, count down while the master waits.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired_c = (TIMEOUT != 0) && enable && (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between IF fetches and MEM-stage
// data accesses; data wins, flushed fetches complete on the bus but are dropped.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic              d_word,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              stall_fetch,
    output logic              stall_pipe,
    output logic              bus_err,
    output logic              m_req,
    output logic              m_we,
    output logic              m_word,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              m_req_d;
    logic              m_we_d;
    logic              m_word_d;
    logic [ADDR_W-1:0] m_addr_d;
    logic [DATA_W-1:0] m_wdata_d;
    logic [DATA_W-1:0] if_rdata_d;
    logic              if_ready_d;
    logic [DATA_W-1:0] d_rdata_d;
    logic              d_ready_d;
    logic              bus_err_d;

    logic busy;
    logic ack_expired_c;
    logic d_req;
    logic f_req;

    // A request still high in its own ready cycle is already served.
    assign d_req = (d_rd | d_wr) & ~d_ready;
    assign f_req = if_req & ~if_ready;
    assign busy  = is_busy(state_q);

    assign stall_pipe  = ~rst & ((state_q == D_BUSY) | d_req);
    assign stall_fetch = stall_pipe | (~rst & f_req);

    ack_timeout_ctr #(
        .TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timeout (
        .clock     (clock),
        .rst       (rst),
        .clear     (~busy | m_ack),
        .enable    (busy),
        .expired_c (ack_expired_c)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_word   <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_rdata <= '0;
            if_ready <= 1'b0;
            d_rdata  <= '0;
            d_ready  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_req    <= m_req_d;
            m_we     <= m_we_d;
            m_word   <= m_word_d;
            m_addr   <= m_addr_d;
            m_wdata  <= m_wdata_d;
            if_rdata <= if_rdata_d;
            if_ready <= if_ready_d;
            d_rdata  <= d_rdata_d;
            d_ready  <= d_ready_d;
            bus_err  <= bus_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        m_req_d    = m_req;
        m_we_d     = m_we;
        m_word_d   = m_word;
        m_addr_d   = m_addr;
        m_wdata_d  = m_wdata;
        if_rdata_d = if_rdata;
        if_ready_d = 1'b0;
        d_rdata_d  = d_rdata;
        d_ready_d  = 1'b0;
        bus_err_d  = bus_err;

        case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d   = D_BUSY;
                    m_req_d   = 1'b1;
                    m_we_d    = d_wr;
                    m_word_d  = d_word;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                end else if (f_req) begin
                    state_d   = F_BUSY;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_word_d  = SIZE_WORD;
                    m_addr_d  = if_addr;
                    m_wdata_d = '0;
                end
            end
            D_BUSY: begin
                if (m_ack) begin
                    state_d   = IDLE;
                    m_req_d   = 1'b0;
                    d_ready_d = 1'b1;
                    if (!m_we) begin
                        d_rdata_d = m_rdata;
                    end
                end
            end
            F_BUSY: begin
                if (m_ack) begin
                    state_d = IDLE;
                    m_req_d = 1'b0;
                    if (!flush) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = m_rdata;
                    end
                end else if (flush) begin
                    state_d = F_DROP;
                end
            end
            F_DROP: begin
                if (m_ack) begin
                    state_d = IDLE;
                    m_req_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase

        // Abandon a transaction the memory never acknowledged.
        if (ack_expired_c && !m_ack) begin
            state_d   = IDLE;
            m_req_d   = 1'b0;
            bus_err_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a simple
// delayed-acknowledge memory responder.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clock;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_rd;
    logic        d_wr;
    logic        d_word;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        flush;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        stall_fetch;
    logic        stall_pipe;
    logic        bus_err;
    logic        m_req;
    logic        m_we;
    logic        m_word;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    int checks = 0;
    int errors = 0;

    logic        ack_enable = 1'b1;
    int          ack_delay  = 1;
    logic [31:0] ack_data   = '0;
    int          wait_cnt   = 0;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .ACK_TIMEOUT (15)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .d_rd        (d_rd),
        .d_wr        (d_wr),
        .d_word      (d_word),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .flush       (flush),
        .if_rdata    (if_rdata),
        .if_ready    (if_ready),
        .d_rdata     (d_rdata),
        .d_ready     (d_ready),
        .stall_fetch (stall_fetch),
        .stall_pipe  (stall_pipe),
        .bus_err     (bus_err),
        .m_req       (m_req),
        .m_we        (m_we),
        .m_word      (m_word),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .m_ack       (m_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory: acks on the ack_delay-th negedge that m_req is seen high.
    initial begin
        m_ack   = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clock);
            if (m_req && ack_enable) begin
                wait_cnt++;
                if (wait_cnt == ack_delay) begin
                    m_ack   = 1'b1;
                    m_rdata = ack_data;
                end else begin
                    m_ack = 1'b0;
                end
            end else begin
                wait_cnt = 0;
                m_ack    = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 0; if_addr = 0; d_rd = 0; d_wr = 0; d_word = 0;
        d_addr = 0; d_wdata = 0; flush = 0;
        tick();
        tick();
        checks++;
        if ({m_req, m_we, m_word, if_ready, d_ready, bus_err, stall_pipe, stall_fetch} !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=00000000",
                {m_req, m_we, m_word, if_ready, d_ready, bus_err, stall_pipe, stall_fetch});
        end
        checks++;
        if ({m_addr, if_rdata, d_rdata} !== 96'h0) begin
            errors++; $display("FAIL reset_data got=%h exp=0", {m_addr, if_rdata, d_rdata});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lone_fetch();
        int k;
        ack_delay = 2; ack_data = 32'h8C220004;
        if_req = 1'b1; if_addr = 32'h40;
        #1;
        checks++;
        if (stall_fetch !== 1'b1) begin errors++; $display("FAIL fetch_stall_req got=%b exp=1", stall_fetch); end
        tick();
        checks++;
        if ({m_req, m_we, m_word} !== 3'b101 || m_addr !== 32'h40) begin
            errors++; $display("FAIL fetch_issue got req/we/word=%b addr=%h exp=101 40", {m_req, m_we, m_word}, m_addr);
        end
        k = 0;
        while (!if_ready && k < 20) begin tick(); k++; end
        checks++;
        if (k !== 2) begin errors++; $display("FAIL fetch_latency got=%0d exp=2", k); end
        checks++;
        if (if_rdata !== 32'h8C220004) begin errors++; $display("FAIL fetch_rdata got=%h exp=8c220004", if_rdata); end
        checks++;
        if (stall_fetch !== 1'b0) begin errors++; $display("FAIL fetch_stall_ready got=%b exp=0", stall_fetch); end
        if_req = 1'b0;
        tick();
        checks++;
        if ({if_ready, m_req, stall_fetch} !== 3'b000) begin
            errors++; $display("FAIL fetch_after got=%b exp=000", {if_ready, m_req, stall_fetch});
        end
    endtask

    task automatic test_data_priority();
        int k;
        ack_delay = 1; ack_data = 32'h12345678;
        d_rd = 1'b1; d_word = 1'b1; d_addr = 32'h100;
        if_req = 1'b1; if_addr = 32'h44;
        #1;
        checks++;
        if (stall_pipe !== 1'b1) begin errors++; $display("FAIL prio_stall_req got=%b exp=1", stall_pipe); end
        tick();
        checks++;
        if (m_req !== 1'b1 || m_addr !== 32'h100 || m_we !== 1'b0 || stall_pipe !== 1'b1) begin
            errors++; $display("FAIL prio_issue got req=%b addr=%h we=%b stall=%b exp=1 100 0 1",
                m_req, m_addr, m_we, stall_pipe);
        end
        k = 0;
        while (!d_ready && k < 20) begin tick(); k++; end
        checks++;
        if (k !== 1 || d_rdata !== 32'h12345678) begin
            errors++; $display("FAIL prio_load got lat=%0d data=%h exp=1 12345678", k, d_rdata);
        end
        checks++;
        if (stall_pipe !== 1'b0 || stall_fetch !== 1'b1 || if_ready !== 1'b0) begin
            errors++; $display("FAIL prio_ready_cycle got stall_pipe=%b stall_fetch=%b if_ready=%b exp=0 1 0",
                stall_pipe, stall_fetch, if_ready);
        end
        d_rd = 1'b0; ack_data = 32'h00000013;
        tick();
        checks++;
        if (m_req !== 1'b1 || m_addr !== 32'h44) begin
            errors++; $display("FAIL prio_fetch_issue got req=%b addr=%h exp=1 44", m_req, m_addr);
        end
        k = 0;
        while (!if_ready && k < 20) begin tick(); k++; end
        checks++;
        if (!if_ready || if_rdata !== 32'h00000013) begin
            errors++; $display("FAIL prio_fetch_data got ready=%b data=%h exp=1 13", if_ready, if_rdata);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_store_byte();
        int k;
        ack_delay = 2; ack_data = 32'hDEADBEEF;
        d_wr = 1'b1; d_word = 1'b0; d_addr = 32'h203; d_wdata = 32'hAB;
        tick();
        checks++;
        if ({m_req, m_we, m_word} !== 3'b110 || m_wdata !== 32'hAB || m_addr !== 32'h203) begin
            errors++; $display("FAIL store_issue got req/we/word=%b wdata=%h addr=%h exp=110 ab 203",
                {m_req, m_we, m_word}, m_wdata, m_addr);
        end
        k = 0;
        while (!d_ready && k < 20) begin tick(); k++; end
        checks++;
        if (!d_ready || d_rdata !== 32'h12345678) begin
            errors++; $display("FAIL store_ready got ready=%b d_rdata=%h exp=1 12345678", d_ready, d_rdata);
        end
        d_wr = 1'b0;
        tick();
        checks++;
        if (d_ready !== 1'b0 || m_req !== 1'b0) begin
            errors++; $display("FAIL store_after got ready=%b req=%b exp=0 0", d_ready, m_req);
        end
    endtask

    task automatic test_flush();
        int k;
        int pulses;
        ack_delay = 4; ack_data = 32'hBAD0BAD0;
        if_req = 1'b1; if_addr = 32'h48;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; if_addr = 32'h80;
        checks++;
        if (dut.state_q !== F_DROP || m_req !== 1'b1 || m_addr !== 32'h48) begin
            errors++; $display("FAIL flush_drop got state=%0d req=%b addr=%h exp=3 1 48", dut.state_q, m_req, m_addr);
        end
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (if_ready) pulses++;
            checks++;
            if (m_req !== 1'b1) begin errors++; $display("FAIL flush_hold got req=%b exp=1", m_req); end
        end
        tick();
        if (if_ready) pulses++;
        checks++;
        if (m_req !== 1'b0 || dut.state_q !== IDLE) begin
            errors++; $display("FAIL flush_done got req=%b state=%0d exp=0 0", m_req, dut.state_q);
        end
        ack_delay = 1; ack_data = 32'h20020001;
        tick();
        if (if_ready) pulses++;
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL flush_no_ready got=%0d exp=0", pulses); end
        checks++;
        if (m_req !== 1'b1 || m_addr !== 32'h80) begin
            errors++; $display("FAIL flush_next_issue got req=%b addr=%h exp=1 80", m_req, m_addr);
        end
        k = 0;
        while (!if_ready && k < 20) begin tick(); k++; end
        checks++;
        if (!if_ready || if_rdata !== 32'h20020001) begin
            errors++; $display("FAIL flush_next_data got ready=%b data=%h exp=1 20020001", if_ready, if_rdata);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int k;
        ack_enable = 1'b0;
        d_rd = 1'b1; d_word = 1'b1; d_addr = 32'h300;
        tick();
        checks++;
        if (m_req !== 1'b1 || bus_err !== 1'b0) begin
            errors++; $display("FAIL timeout_issue got req=%b err=%b exp=1 0", m_req, bus_err);
        end
        k = 0;
        while (!bus_err && k < 40) begin tick(); k++; end
        d_rd = 1'b0;
        checks++;
        if (k !== 15) begin errors++; $display("FAIL timeout_cycles got=%0d exp=15", k); end
        checks++;
        if (m_req !== 1'b0 || d_ready !== 1'b0 || dut.state_q !== IDLE) begin
            errors++; $display("FAIL timeout_abort got req=%b ready=%b state=%0d exp=0 0 0", m_req, d_ready, dut.state_q);
        end
        ack_enable = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b exp=1", bus_err); end
    endtask

    task automatic test_reset_mid();
        int k;
        ack_delay = 8; ack_data = 32'hCAFEF00D;
        d_rd = 1'b1; d_word = 1'b1; d_addr = 32'h104;
        tick();
        checks++;
        if (m_req !== 1'b1 || stall_pipe !== 1'b1) begin
            errors++; $display("FAIL rstmid_issue got req=%b stall=%b exp=1 1", m_req, stall_pipe);
        end
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({m_req, stall_pipe, d_ready, bus_err} !== 4'b0000) begin
            errors++; $display("FAIL rstmid_async got req/stall/ready/err=%b exp=0000",
                {m_req, stall_pipe, d_ready, bus_err});
        end
        ack_delay = 1;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (m_req !== 1'b1 || m_addr !== 32'h104) begin
            errors++; $display("FAIL rstmid_reissue got req=%b addr=%h exp=1 104", m_req, m_addr);
        end
        k = 0;
        while (!d_ready && k < 20) begin tick(); k++; end
        checks++;
        if (!d_ready || d_rdata !== 32'hCAFEF00D) begin
            errors++; $display("FAIL rstmid_load got ready=%b data=%h exp=1 cafef00d", d_ready, d_rdata);
        end
        d_rd = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_data_priority();
        test_store_byte();
        test_flush();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
